// File: rtl/clock_monitor.sv
// clock_monitor: counts synchronized rising edges of a monitored clock per gate window and reports lock/fault.
// Optional stuck-clock detector enabled by defining MON_STUCK_DETECT_EN.
module clock_monitor #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned EXP_EDGES   = 512,
    parameter int unsigned TOLERANCE   = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLKIN_IN,
    input  logic             RST_IN,
    input  logic             MON_CLK_IN,
    input  logic             EN_IN,
    output logic             LOCKED_OUT,
    output logic [CNT_W-1:0] EDGE_COUNT_OUT,
    output logic             COUNT_VALID_OUT,
    output logic             FAULT_OUT
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_EDGES);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOLERANCE);
`ifdef MON_STUCK_DETECT_EN
    localparam int unsigned STUCK_CYCLES = GATE_CYCLES / 4;
    localparam int unsigned IDLE_W       = $clog2(STUCK_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  s1_q, s2_q, s3_q;
    logic [GATE_W-1:0]     gate_q, gate_d;
    logic [CNT_W-1:0]      edge_q, edge_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic                  locked_q, locked_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
`ifdef MON_STUCK_DETECT_EN
    logic [IDLE_W-1:0]     idle_q, idle_d;
`endif

    logic                  edge_det;
    logic                  win_end;
    logic [CNT_W-1:0]      edge_sum;
    logic signed [CNT_W:0] diff;
    logic                  good_win;

    // Window arithmetic: saturated count including an edge detected on the closing cycle.
    always_comb begin
        edge_det = s2_q & ~s3_q;
        win_end  = (gate_q == GATE_W'(GATE_CYCLES - 1));
        edge_sum = (edge_det && (edge_q != '1)) ? CNT_W'(edge_q + 1'b1) : edge_q;
        diff     = $signed({1'b0, edge_sum}) - EXP_S;
        good_win = (diff <= TOL_S) && (diff >= -TOL_S);
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        count_d  = count_q;
        good_d   = good_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        fault_d  = fault_q;
`ifdef MON_STUCK_DETECT_EN
        idle_d   = idle_q;
`endif

        if (state_q == ST_IDLE) begin
            gate_d   = '0;
            edge_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
`ifdef MON_STUCK_DETECT_EN
            idle_d   = '0;
`endif
            if (EN_IN) begin
                state_d = ST_ACQUIRE;
            end
        end else if (!EN_IN) begin
            // Disable wins over a coincident window end; count and fault are retained.
            state_d  = ST_IDLE;
            gate_d   = '0;
            edge_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
`ifdef MON_STUCK_DETECT_EN
            idle_d   = '0;
`endif
        end else begin
            gate_d = win_end ? '0 : GATE_W'(gate_q + 1'b1);
            edge_d = win_end ? '0 : edge_sum;
            if (win_end) begin
                count_d = edge_sum;
                valid_d = 1'b1;
                if (good_win) begin
                    if (state_q == ST_ACQUIRE) begin
                        good_d = GOOD_W'(good_q + 1'b1);
                        if (GOOD_W'(good_q + 1'b1) == GOOD_W'(LOCK_COUNT)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end else begin
                    good_d = '0;
                    if (state_q == ST_LOCKED) begin
                        state_d  = ST_ACQUIRE;
                        locked_d = 1'b0;
                        fault_d  = 1'b1;
                    end
                end
            end
`ifdef MON_STUCK_DETECT_EN
            // A long edge gap drops lock early without disturbing the gate window.
            idle_d = edge_det ? '0 : IDLE_W'(idle_q + 1'b1);
            if (!edge_det && (idle_q == IDLE_W'(STUCK_CYCLES - 1))) begin
                idle_d   = '0;
                good_d   = '0;
                state_d  = ST_ACQUIRE;
                locked_d = 1'b0;
                if (state_q == ST_LOCKED) begin
                    fault_d = 1'b1;
                end
            end
`endif
        end
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge CLKIN_IN) begin
        if (RST_IN) begin
            state_q  <= ST_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            gate_q   <= '0;
            edge_q   <= '0;
            count_q  <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
`ifdef MON_STUCK_DETECT_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            s1_q     <= MON_CLK_IN;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            count_q  <= count_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
`ifdef MON_STUCK_DETECT_EN
            idle_q   <= idle_d;
`endif
        end
    end

    assign LOCKED_OUT      = locked_q;
    assign EDGE_COUNT_OUT  = count_q;
    assign COUNT_VALID_OUT = valid_q;
    assign FAULT_OUT       = fault_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed scenarios plus randomized stimulus, checked every cycle against a window-level model.
module tb_clock_monitor;

    localparam int GATE  = 64;
    localparam int EXP   = 32;
    localparam int TOL   = 1;
    localparam int LOCKN = 2;
    localparam int CW    = 8;
    localparam int SATV  = (1 << CW) - 1;

    bit          clk = 1'b0;
    logic        rst = 1'b0;
    logic        mon = 1'b0;
    logic        en  = 1'b0;
    logic        locked_o;
    logic [CW-1:0] count_o;
    logic        valid_o;
    logic        fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    clock_monitor #(
        .GATE_CYCLES(GATE), .EXP_EDGES(EXP), .TOLERANCE(TOL),
        .LOCK_COUNT(LOCKN), .CNT_W(CW)
    ) dut (
        .CLKIN_IN(clk), .RST_IN(rst), .MON_CLK_IN(mon), .EN_IN(en),
        .LOCKED_OUT(locked_o), .EDGE_COUNT_OUT(count_o),
        .COUNT_VALID_OUT(valid_o), .FAULT_OUT(fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Monitored clock source: half-period in CLKIN cycles, 0 = held low, -1 = random bits.
    int mon_half = 0;
    int skip_req = 0;
    int skip_done = 0;
    int ph = 0;
    always @(posedge clk) begin
        #1;
        if (mon_half < 0) mon = 1'($urandom);
        else if (mon_half == 0) mon = 1'b0;
        else begin
            ph++;
            if (ph >= mon_half) begin
                ph = 0;
                if (skip_req != skip_done) skip_done = skip_req;
                else mon = ~mon;
            end
        end
    end

    // Behavioural model: MON samples as seen by the DUT, per-window edge tally and lock bookkeeping.
    bit m_known = 0;
    bit m_active = 0;
    bit m_locked = 0;
    bit m_fault = 0;
    bit m_valid = 0;
    int m_count = 0;
    int m_pos = 0;
    int m_edges = 0;
    int m_streak = 0;
    int m_quiet = 0;
    bit q_mon[$];

    always @(posedge clk) begin
        bit e;
        int d;
        e = (q_mon.size() >= 3) && q_mon[q_mon.size()-2] && !q_mon[q_mon.size()-3];
        if (rst) begin
            q_mon.delete();
            repeat (3) q_mon.push_back(1'b0);
        end else begin
            q_mon.push_back(mon);
            if (q_mon.size() > 4) void'(q_mon.pop_front());
        end
        m_valid = 0;
        if (rst) begin
            m_known = 1; m_active = 0; m_locked = 0; m_fault = 0; m_count = 0;
            m_pos = 0; m_edges = 0; m_streak = 0; m_quiet = 0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1; m_pos = 0; m_edges = 0; m_streak = 0; m_quiet = 0;
            end
        end else if (!en) begin
            m_active = 0; m_locked = 0; m_pos = 0; m_edges = 0; m_streak = 0; m_quiet = 0;
        end else begin
            m_edges = (m_edges + int'(e) > SATV) ? SATV : m_edges + int'(e);
            if (m_pos == GATE - 1) begin
                m_count = m_edges;
                m_valid = 1;
                d = m_edges - EXP;
                if (d < 0) d = -d;
                if (d <= TOL) m_streak++;
                else begin
                    m_streak = 0;
                    if (m_locked) begin m_locked = 0; m_fault = 1; end
                end
                if (!m_locked && m_streak >= LOCKN) m_locked = 1;
                m_edges = 0;
                m_pos = 0;
            end else m_pos++;
`ifdef MON_STUCK_DETECT_EN
            m_quiet = e ? 0 : m_quiet + 1;
            if (m_quiet == GATE / 4) begin
                m_quiet = 0;
                if (m_locked) m_fault = 1;
                m_locked = 0;
                m_streak = 0;
            end
`endif
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("locked", int'(locked_o), int'(m_locked));
            chk("valid", int'(valid_o), int'(m_valid));
            chk("count", int'(count_o), m_count);
            chk("fault", int'(fault_o), int'(m_fault));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int cnt);
        bit got;
        got = 0;
        cnt = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (valid_o) begin
                got = 1;
                cnt = int'(count_o);
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        cyc();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int sum;
        int n;
        bit ok;

        // 1: divide-by-2 locks after two windows
        en = 0; mon_half = 1;
        do_reset();
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_fault", int'(fault_o), 0);
        en = 1;
        wait_valid("t1_w1", c);
        chk_range("t1_w1_count", c, 31, 32);
        wait_valid("t1_w2", c);
        chk_range("t1_w2_count", c, 31, 32);
        chk("t1_locked", int'(locked_o), 1);
        chk("t1_fault", int'(fault_o), 0);

        // 2: divide-by-4 never locks
        mon_half = 2;
        do_reset();
        wait_valid("t2_w1", c);
        wait_valid("t2_w2", c);
        chk("t2_w2_count", c, 16);
        wait_valid("t2_w3", c);
        chk("t2_w3_count", c, 16);
        chk("t2_locked", int'(locked_o), 0);
        chk("t2_fault", int'(fault_o), 0);

        // 3: lock, then stop the monitored clock
        mon_half = 1;
        do_reset();
        wait_valid("t3_w1", c);
        wait_valid("t3_w2", c);
        chk("t3_locked_before", int'(locked_o), 1);
        mon_half = 0;
`ifdef MON_STUCK_DETECT_EN
        ok = 0;
        for (int i = 0; i < 24 && !ok; i++) begin
            @(negedge clk);
            if (!locked_o) ok = 1;
        end
        chk("t3_stuck_drop", int'(ok), 1);
        chk("t3_stuck_fault", int'(fault_o), 1);
        cyc();
`else
        ok = 0;
        for (int w = 0; w < 3 && !ok; w++) begin
            wait_valid("t3_stop", c);
            if (c >= 0 && c <= 1) ok = 1;
        end
        chk("t3_count_low", int'(ok), 1);
`endif
        chk("t3_locked_after", int'(locked_o), 0);
        chk("t3_fault_after", int'(fault_o), 1);

        // 5: relock with fault set, then reset mid-window
        mon_half = 1;
        repeat (4) wait_valid("t5_relock", c);
        chk("t5_locked", int'(locked_o), 1);
        chk("t5_fault_sticky", int'(fault_o), 1);
        repeat (20) cyc();
        rst = 1; en = 0;
        cyc();
        chk("t5_locked_rst", int'(locked_o), 0);
        chk("t5_count_rst", int'(count_o), 0);
        chk("t5_valid_rst", int'(valid_o), 0);
        chk("t5_fault_rst", int'(fault_o), 0);
        rst = 0;
        repeat (3) cyc();
        en = 1;
        n = 0;
        for (int i = 1; i <= 120 && n == 0; i++) begin
            @(negedge clk);
            if (valid_o) n = i;
        end
        chk("t5_first_valid_cycle", n, 66);
        cyc();

        // 4: disable while locked, then relock over two windows
        do_reset();
        wait_valid("t4_w1", c);
        wait_valid("t4_w2", c);
        chk("t4_locked", int'(locked_o), 1);
        en = 0;
        cyc();
        chk("t4_locked_off", int'(locked_o), 0);
        chk("t4_fault", int'(fault_o), 0);
        repeat (9) cyc();
        en = 1;
        wait_valid("t4_r1", c);
        chk("t4_relock_w1", int'(locked_o), 0);
        wait_valid("t4_r2", c);
        chk("t4_relock_w2", int'(locked_o), 1);

        // 6: boundary edges counted exactly once, in both detection phases
        for (int p = 0; p < 2; p++) begin
            wait_valid("t6_skip", c);
            sum = 0;
            for (int w = 0; w < 4; w++) begin
                wait_valid("t6_win", c);
                sum += c;
            end
            chk("t6_sum4", sum, 128);
            skip_req++;
        end

        // Randomized segments: clock rate, enable drops and resets
        for (int seg = 0; seg < 40; seg++) begin
            int r;
            int v;
            r = $urandom_range(0, 9);
            if (r == 0) do_reset();
            v = $urandom_range(0, 7);
            mon_half = (v == 0) ? 0 : (v == 5) ? -1 : (v >= 6) ? 1 : v;
            if (r <= 2) begin
                en = 0;
                repeat ($urandom_range(1, 20)) cyc();
            end
            en = 1;
            repeat ($urandom_range(64, 300)) cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
